vpu_cmd_responder: RTL and testbench
====================================

VPU_CMD_RESPONDER -- requirements
Module: vpu_cmd_responder

Interface
REQ-001 SHALL have parameter CRT_LAT, default 4: busy cycles for create.
REQ-002 SHALL have parameter XFRM_LAT, default 8: busy cycles for translate, rotate and scale.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port go  input  1  command strobe, one cycle, from the sequencer.
REQ-006 SHALL have port gmt_op  input  4  opcode: 0 crt, 1 del, 2 del_all, 3 trans_one, 4 trans, 6 rotl, 7 rotr, 8 scale.
REQ-007 SHALL have port gmt_code  input  4  op modifier {pt,xy}, {cen,amt[2:0]} or scale amt.
REQ-008 SHALL have port obj_type  input  2  object type for crt (1 line, 2 tri, 3 quad; 0 illegal).
REQ-009 SHALL have port obj_num_in  input  5  target object for del/trans/rot/scale.
REQ-010 SHALL have port busy  output  1  command in progress.
REQ-011 SHALL have port obj_mem_full_out  output  1  all 32 slots allocated.
REQ-012 SHALL have port lst_stored_obj_out  output  5  slot allocated by the most recent successful crt.
REQ-013 SHALL have port cmd_done  output  1  one-cycle pulse when busy falls.
REQ-014 SHALL have port cmd_err  output  1  error status of the last completed command, held until the next cmd_done.

Function
REQ-015 SHALL implement states IDLE, DECODE, EXEC, DONE.
REQ-016 IDLE: go=1 SHALL latch gmt_op, gmt_code, obj_type and obj_num_in, then move to DECODE; busy SHALL be 1 from the next cycle.
REQ-017 DECODE (1 cycle) SHALL classify the command, load the latency counter and set the error flag; it SHALL then go to EXEC, or straight to DONE on error.
REQ-018 Latency: crt CRT_LAT; del 2; del_all 2; trans_one/trans/rotl/rotr/scale XFRM_LAT; counter counts down to 1 in EXEC, then goes to DONE.
REQ-019 DONE (1 cycle) SHALL commit slot updates, pulse cmd_done, update cmd_err, drop busy at the end of the cycle and return to IDLE.
REQ-020 busy SHALL be high in DECODE, EXEC and DONE, and low in IDLE only.
REQ-021 go while busy=1 SHALL be ignored, with no queueing.
REQ-022 crt SHALL allocate the lowest-numbered free slot in the 32-bit valid map and write that index to lst_stored_obj_out.
REQ-023 del SHALL clear valid[obj_num_in]; del_all SHALL clear the whole map and reset lst_stored_obj_out to 0.
REQ-024 trans/rot/scale SHALL NOT change the map.
REQ-025 Error cases SHALL be: undefined opcode (5, 9-15); crt when full; crt with obj_type 0; any del/trans/rot/scale on an unallocated slot.
REQ-026 An error command SHALL leave the map and lst_stored_obj_out unchanged; its total busy time is 2 cycles (DECODE + DONE).
REQ-027 obj_mem_full_out SHALL equal the AND of the valid map, registered and updated in DONE.
REQ-028 A crt that fills the last slot SHALL assert obj_mem_full_out in the same cycle as its cmd_done.
REQ-029 Total busy cycles for a legal command SHALL be latency + 2.

Reset
REQ-030 rst_n low SHALL force IDLE, valid map 0, and outputs busy=0, obj_mem_full_out=0, lst_stored_obj_out=0, cmd_done=0, cmd_err=0, immediately (asynchronous).
REQ-031 Reset mid-command SHALL abort the command with no cmd_done and no map commit.
REQ-032 After release, the first go SHALL be accepted on the first clock edge.

Configuration
REQ-033 Macro VPU_RESP_STATS_EN defined SHALL add outputs cmd_cnt[15:0] and err_cnt[15:0].
REQ-034 With the macro, cmd_cnt SHALL increment on every cmd_done and err_cnt on every cmd_done with an error; both wrap at 16'hFFFF to 0 and reset to 0.
REQ-035 Without the macro, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 After reset, crt type 3, then crt type 2 -> lst_stored_obj_out 0 then 1; each busy for 6 cycles; cmd_err=0.
REQ-037 32 crt commands -> obj_mem_full_out=1 with the 32nd cmd_done; a 33rd crt -> cmd_err=1, busy 2 cycles, lst_stored_obj_out stays 31.
REQ-038 After the 32 crt commands of REQ-037: del obj 1, then crt -> lst_stored_obj_out=1, obj_mem_full_out toggles 0 then 1.
REQ-039 rotr on unallocated obj 5 -> cmd_err=1; gmt_op 4'hB -> cmd_err=1; trans on obj 0 -> busy 10 cycles, cmd_err=0.
REQ-040 go pulsed 3 cycles into a trans -> ignored, exactly one cmd_done.
REQ-041 rst_n low during EXEC of a crt -> busy=0 immediately, map empty; next crt -> slot 0.

Source files
------------

// File: rtl/vpu_cmd_responder.sv
// vpu_cmd_responder: accepts one geometry command per go strobe, checks it against the
// 32-slot object valid map, models the command's busy time and reports completion.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   go                  one-cycle command strobe; ignored while busy
//   gmt_op, gmt_code    opcode and modifier of the command
//   obj_type            object type for crt (0 is illegal)
//   obj_num_in          target slot for del / trans / rot / scale
//   busy                high from the cycle after go until the end of DONE
//   obj_mem_full_out    all 32 slots allocated
//   lst_stored_obj_out  slot taken by the most recent successful crt
//   cmd_done            one-cycle pulse in the DONE cycle
//   cmd_err             error status of the last completed command
//   cmd_cnt, err_cnt    completed / failed command counters (only with VPU_RESP_STATS_EN)
//
// Optional feature macro: VPU_RESP_STATS_EN adds the cmd_cnt / err_cnt counters.

module vpu_cmd_responder #(
  parameter int unsigned CRT_LAT  = 4,
  parameter int unsigned XFRM_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [3:0]  gmt_op,
  input  logic [3:0]  gmt_code,
  input  logic [1:0]  obj_type,
  input  logic [4:0]  obj_num_in,
  output logic        busy,
  output logic        obj_mem_full_out,
  output logic [4:0]  lst_stored_obj_out,
  output logic        cmd_done,
  output logic        cmd_err
`ifdef VPU_RESP_STATS_EN
  ,
  output logic [15:0] cmd_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [3:0] OpCrt      = 4'd0;
  localparam logic [3:0] OpDel      = 4'd1;
  localparam logic [3:0] OpDelAll   = 4'd2;
  localparam logic [3:0] OpTransOne = 4'd3;
  localparam logic [3:0] OpTrans    = 4'd4;
  localparam logic [3:0] OpRotl     = 4'd6;
  localparam logic [3:0] OpRotr     = 4'd7;
  localparam logic [3:0] OpScale    = 4'd8;

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  code_q, code_d;
  logic [1:0]  type_q, type_d;
  logic [4:0]  num_q, num_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] valid_q, valid_d;
  logic        full_q, full_d;
  logic [4:0]  lst_q, lst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cmd_err_q, cmd_err_d;
`ifdef VPU_RESP_STATS_EN
  logic [15:0] cmd_cnt_q, cmd_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
`endif

  logic        dec_err;
  logic [15:0] dec_lat;
  logic [4:0]  free_idx;
  logic        cur_err;
  logic        commit;

  // The modifier is captured for the downstream datapath; the responder does not decode it.
  logic unused_code;
  assign unused_code = ^code_q;

  // Lowest-numbered free slot; only meaningful when the map is not full.
  always_comb begin
    free_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = 5'(i);
    end
  end

  // Classify the latched command against the current map.
  always_comb begin
    dec_err = 1'b0;
    dec_lat = 16'd2;
    case (op_q)
      OpCrt: begin
        dec_lat = 16'(CRT_LAT);
        dec_err = (&valid_q) || (type_q == 2'd0);
      end
      OpDel:    dec_err = !valid_q[num_q];
      OpDelAll: dec_err = 1'b0;
      OpTransOne, OpTrans, OpRotl, OpRotr, OpScale: begin
        dec_lat = 16'(XFRM_LAT);
        dec_err = !valid_q[num_q];
      end
      default:  dec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    code_d    = code_q;
    type_d    = type_q;
    num_d     = num_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    full_d    = full_q;
    lst_d     = lst_q;
    cmd_err_d = cmd_err_q;
`ifdef VPU_RESP_STATS_EN
    cmd_cnt_d = cmd_cnt_q;
    err_cnt_d = err_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (go) begin
          op_d    = gmt_op;
          code_d  = gmt_code;
          type_d  = obj_type;
          num_d   = obj_num_in;
          state_d = StDecode;
        end
      end
      StDecode: begin
        err_d   = dec_err;
        cnt_d   = dec_lat;
        state_d = dec_err ? StDone : StExec;
      end
      StExec: begin
        if (cnt_q <= 16'd1) state_d = StDone;
        else                cnt_d   = cnt_q - 16'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Results are committed on entry to DONE so that cmd_done, cmd_err, the map and
    // obj_mem_full_out all become visible together in the DONE cycle.
    commit  = (state_q != StDone) && (state_d == StDone);
    cur_err = (state_q == StDecode) ? dec_err : err_q;
    if (commit) begin
      cmd_err_d = cur_err;
      if (!cur_err) begin
        case (op_q)
          OpCrt: begin
            valid_d[free_idx] = 1'b1;
            lst_d             = free_idx;
          end
          OpDel:    valid_d[num_q] = 1'b0;
          OpDelAll: begin
            valid_d = '0;
            lst_d   = '0;
          end
          default: ;
        endcase
      end
      full_d = &valid_d;
`ifdef VPU_RESP_STATS_EN
      cmd_cnt_d = cmd_cnt_q + 16'd1;
      if (cur_err) err_cnt_d = err_cnt_q + 16'd1;
`endif
    end

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      code_q    <= '0;
      type_q    <= '0;
      num_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= '0;
      full_q    <= 1'b0;
      lst_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
`ifdef VPU_RESP_STATS_EN
      cmd_cnt_q <= '0;
      err_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      code_q    <= code_d;
      type_q    <= type_d;
      num_q     <= num_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      full_q    <= full_d;
      lst_q     <= lst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cmd_err_q <= cmd_err_d;
`ifdef VPU_RESP_STATS_EN
      cmd_cnt_q <= cmd_cnt_d;
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign busy               = busy_q;
  assign obj_mem_full_out   = full_q;
  assign lst_stored_obj_out = lst_q;
  assign cmd_done           = done_q;
  assign cmd_err            = cmd_err_q;
`ifdef VPU_RESP_STATS_EN
  assign cmd_cnt            = cmd_cnt_q;
  assign err_cnt            = err_cnt_q;
`endif

endmodule

// File: tb/tb_vpu_cmd_responder.sv
// Directed bench for vpu_cmd_responder with default latencies (crt 4, transforms 8).
module tb_vpu_cmd_responder;

  logic       clk;
  logic       rst_n;
  logic       go;
  logic [3:0] gmt_op;
  logic [3:0] gmt_code;
  logic [1:0] obj_type;
  logic [4:0] obj_num_in;
  logic       busy;
  logic       obj_mem_full_out;
  logic [4:0] lst_stored_obj_out;
  logic       cmd_done;
  logic       cmd_err;
`ifdef VPU_RESP_STATS_EN
  logic [15:0] cmd_cnt;
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  vpu_cmd_responder dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .go                 (go),
    .gmt_op             (gmt_op),
    .gmt_code           (gmt_code),
    .obj_type           (obj_type),
    .obj_num_in         (obj_num_in),
    .busy               (busy),
    .obj_mem_full_out   (obj_mem_full_out),
    .lst_stored_obj_out (lst_stored_obj_out),
    .cmd_done           (cmd_done),
    .cmd_err            (cmd_err)
`ifdef VPU_RESP_STATS_EN
    ,
    .cmd_cnt            (cmd_cnt),
    .err_cnt            (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [1:0] typ;
    logic [4:0] num;
    int         exp_busy;
    logic       exp_err;
    logic [4:0] exp_lst;
    logic       exp_full;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one command and watch it to completion plus a short idle tail. extra_go > 0
  // pulses go again that many busy cycles into the command.
  task automatic run_cmd(input logic [3:0] op, input logic [1:0] typ, input logic [4:0] num,
                         input int extra_go, output int busy_cyc, output int dones,
                         output logic err, output logic [4:0] lst, output logic full,
                         output logic full_pre);
    int   k;
    logic prev_full;
    busy_cyc = 0;
    dones    = 0;
    err      = 1'bx;
    lst      = 'x;
    full     = 1'bx;
    full_pre = 1'bx;
    @(negedge clk);
    gmt_op     = op;
    gmt_code   = 4'h3;
    obj_type   = typ;
    obj_num_in = num;
    go         = 1'b1;
    @(negedge clk);
    go        = 1'b0;
    prev_full = obj_mem_full_out;
    k         = 0;
    while (k < 200) begin
      if (busy) busy_cyc++;
      if (cmd_done) begin
        dones++;
        err      = cmd_err;
        lst      = lst_stored_obj_out;
        full     = obj_mem_full_out;
        full_pre = prev_full;
      end
      prev_full = obj_mem_full_out;
      if (!busy) break;
      go = (extra_go > 0) && (k + 1 == extra_go);
      @(negedge clk);
      k++;
    end
    go = 1'b0;
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout: busy still %0d after %0d cycles, required 0", busy, k);
    end
    // Anything after busy falls would be a queued or spurious command.
    repeat (4) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (cmd_done) dones++;
    end
  endtask

  initial begin
    int         bc, dn;
    logic       e, f, fp;
    logic [4:0] l;

    //            name          op     typ   num   busy err lst   full
    vecs[0]  = '{"crt_t3",     4'd0,  2'd3, 5'd0, 6,  0, 5'd0, 0};
    vecs[1]  = '{"crt_t2",     4'd0,  2'd2, 5'd0, 6,  0, 5'd1, 0};
    vecs[2]  = '{"crt_t0",     4'd0,  2'd0, 5'd0, 2,  1, 5'd1, 0};
    vecs[3]  = '{"rotr_5",     4'd7,  2'd0, 5'd5, 2,  1, 5'd1, 0};
    vecs[4]  = '{"op_b",       4'hB,  2'd1, 5'd0, 2,  1, 5'd1, 0};
    vecs[5]  = '{"op_5",       4'd5,  2'd1, 5'd0, 2,  1, 5'd1, 0};
    vecs[6]  = '{"trans_0",    4'd4,  2'd0, 5'd0, 10, 0, 5'd1, 0};
    vecs[7]  = '{"rotl_1",     4'd6,  2'd0, 5'd1, 10, 0, 5'd1, 0};
    vecs[8]  = '{"scale_1",    4'd8,  2'd0, 5'd1, 10, 0, 5'd1, 0};
    vecs[9]  = '{"trans1_0",   4'd3,  2'd0, 5'd0, 10, 0, 5'd1, 0};
    vecs[10] = '{"del_1",      4'd1,  2'd0, 5'd1, 4,  0, 5'd1, 0};
    vecs[11] = '{"del_1_again",4'd1,  2'd0, 5'd1, 2,  1, 5'd1, 0};
    vecs[12] = '{"crt_refill", 4'd0,  2'd1, 5'd0, 6,  0, 5'd1, 0};
    vecs[13] = '{"del_all",    4'd2,  2'd0, 5'd9, 4,  0, 5'd0, 0};
    vecs[14] = '{"trans_empty",4'd4,  2'd0, 5'd0, 2,  1, 5'd0, 0};
    vecs[15] = '{"crt_after",  4'd0,  2'd1, 5'd0, 6,  0, 5'd0, 0};

    rst_n      = 1'b0;
    go         = 1'b0;
    gmt_op     = '0;
    gmt_code   = '0;
    obj_type   = '0;
    obj_num_in = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_full", obj_mem_full_out, 0);
    check("rst_lst", lst_stored_obj_out, 0);
    check("rst_done", cmd_done, 0);
    check("rst_err", cmd_err, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_cmd(vecs[i].op, vecs[i].typ, vecs[i].num, 0, bc, dn, e, l, f, fp);
      check({vecs[i].name, "_busy"}, bc, vecs[i].exp_busy);
      check({vecs[i].name, "_dones"}, dn, 1);
      check({vecs[i].name, "_err"}, e, vecs[i].exp_err);
      check({vecs[i].name, "_lst"}, l, vecs[i].exp_lst);
      check({vecs[i].name, "_full"}, f, vecs[i].exp_full);
    end

    // Slot 0 is in use; 31 more crt commands fill the map.
    for (int i = 1; i <= 31; i++) begin
      run_cmd(4'd0, 2'd1, 5'd0, 0, bc, dn, e, l, f, fp);
      if (i == 30) check("fill_30_full", f, 0);
      if (i == 31) begin
        check("fill_31_lst", l, 31);
        check("fill_31_full", f, 1);
        check("fill_31_full_pre", fp, 0);
        check("fill_31_err", e, 0);
      end
    end

    run_cmd(4'd0, 2'd1, 5'd0, 0, bc, dn, e, l, f, fp);
    check("crt_full_err", e, 1);
    check("crt_full_busy", bc, 2);
    check("crt_full_lst", l, 31);
    check("crt_full_full", f, 1);

    run_cmd(4'd1, 2'd0, 5'd1, 0, bc, dn, e, l, f, fp);
    check("del1_full", f, 0);
    check("del1_lst", l, 31);
    run_cmd(4'd0, 2'd2, 5'd0, 0, bc, dn, e, l, f, fp);
    check("recrt_lst", l, 1);
    check("recrt_full", f, 1);

    // Second go three cycles into a transform must be dropped.
    run_cmd(4'd4, 2'd0, 5'd0, 3, bc, dn, e, l, f, fp);
    check("go_busy_dones", dn, 1);
    check("go_busy_cycles", bc, 10);
    check("go_busy_err", e, 0);

    // Free slot 2 so a crt runs through EXEC, then reset in the middle of it.
    run_cmd(4'd1, 2'd0, 5'd2, 0, bc, dn, e, l, f, fp);
    @(negedge clk);
    gmt_op   = 4'd0;
    obj_type = 2'd1;
    go       = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", cmd_done, 0);
    check("mid_rst_lst", lst_stored_obj_out, 0);
    check("mid_rst_full", obj_mem_full_out, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_cmd(4'd0, 2'd1, 5'd0, 0, bc, dn, e, l, f, fp);
    check("post_rst_busy", bc, 6);
    check("post_rst_lst", l, 0);
    check("post_rst_full", f, 0);
    check("post_rst_err", e, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
